pipe_stage_ctrl: RTL

- Sequencing controller for a linear chain of STAGES pipeline registers in the FP core datapath.
- Tracks a valid bit per stage and drives each register's en and clear inputs.
- Collapses bubbles, applies backpressure from the consumer and an external stall, and flushes the whole pipe on request.
- Sits between the issuing unit (valid/ready in) and the writeback consumer (valid/ready out).

---
 rtl/pipe_stage_ctrl.sv | 85 ++++++++
 1 files changed

// File: rtl/pipe_stage_ctrl.sv
// Valid-bit sequencer for a linear chain of pipeline registers: drives per-stage
// load enables and clears, collapses bubbles, honours backpressure, stall and flush.
module pipe_stage_ctrl #(
  parameter int STAGES = 4,
  parameter int CNT_W  = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              stall,
  input  logic              flush,
  output logic [STAGES-1:0] stage_en,
  output logic [STAGES-1:0] stage_clear,
  output logic [STAGES-1:0] stage_valid,
  output logic [CNT_W-1:0]  occupancy
);

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [CNT_W-1:0]  occ_q;
  logic [CNT_W-1:0]  occ_d;

  logic [STAGES-1:0] up_valid_s;
  logic [STAGES-1:0] can_load_s;
  logic [STAGES-1:0] leave_s;
  logic [STAGES-1:0] load_s;
  logic              go_s;
  logic              acc_s;
  logic              ret_s;

  // Movement is only allowed out of reset, without stall and without flush.
  assign go_s       = rst_n & ~stall & ~flush;
  assign up_valid_s = {v_q[STAGES-2:0], in_valid};

  // Backward advance chain; room tracks whether the stage below can make space.
  always_comb begin
    logic room;
    room       = out_ready;
    can_load_s = {STAGES{1'b0}};
    leave_s    = {STAGES{1'b0}};
    load_s     = {STAGES{1'b0}};
    for (int i = STAGES - 1; i >= 0; i--) begin
      leave_s[i]    = v_q[i] & room & go_s;
      can_load_s[i] = (~v_q[i] | room) & go_s;
      load_s[i]     = can_load_s[i] & up_valid_s[i];
      room          = ~v_q[i] | room;
    end
  end

  assign acc_s = load_s[0];
  assign ret_s = leave_s[STAGES-1];

  // Next-state valid vector and occupancy; flush discards everything in flight.
  always_comb begin
    if (flush) begin
      v_d   = {STAGES{1'b0}};
      occ_d = {CNT_W{1'b0}};
    end else begin
      v_d   = (v_q & ~leave_s) | load_s;
      occ_d = occ_q + {{(CNT_W-1){1'b0}}, acc_s} - {{(CNT_W-1){1'b0}}, ret_s};
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q   <= {STAGES{1'b0}};
      occ_q <= {CNT_W{1'b0}};
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
    end
  end

  assign in_ready    = can_load_s[0];
  assign out_valid   = v_q[STAGES-1] & go_s;
  assign stage_en    = load_s;
  assign stage_clear = {STAGES{flush | ~rst_n}};
  assign stage_valid = v_q;
  assign occupancy   = occ_q;

endmodule
